// File: rtl/gpio_irq_bank.sv
// GPIO pad bank on the ic0 interconnect: direction/open-drain outputs, synchronised inputs,
// edge-detect interrupts. Optional per-pin input debounce is enabled with GPIO_DEBOUNCE_EN.
module gpio_irq_bank #(
  parameter logic [31:0] BASE      = 32'h80030000,
  parameter logic [31:0] OFFSET    = 32'h00000000,
  parameter int          b0_bw     = 8,
  parameter int          DB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              c_sys_rst_n,
  inout  wire [b0_bw-1:0]   b0_data_io,
  input  logic              ic0_c_axi_mst_wr_valid,
  input  logic [31:0]       ic0_axi_mst_wr_addr,
  input  logic [31:0]       ic0_axi_mst_wr_data,
  input  logic              ic0_c_axi_mst_rd_valid,
  input  logic [31:0]       ic0_axi_mst_rd_addr,
  output logic              ic0_c_axi_slv_rd_ready_0,
  output logic [31:0]       ic0_axi_slv_rd_data_0,
  output logic              irq
);

  localparam logic [31:0] REG_BASE = BASE + OFFSET;

  logic [31:0]      wr_off;
  logic [31:0]      rd_off;
  logic [b0_bw-1:0] wd;
  wire  [31:0]      unused_wr_data = ic0_axi_mst_wr_data;

  logic [b0_bw-1:0] dir_q, tri_q, out_q, rise_en, fall_en, pend, mask;
  logic [b0_bw-1:0] s1, s2, f, prev;
  logic [b0_bw-1:0] pend_hit, pend_clr;
  logic [b0_bw-1:0] drv_en, drv_val;

  assign wr_off = ic0_axi_mst_wr_addr - REG_BASE;
  assign rd_off = ic0_axi_mst_rd_addr - REG_BASE;
  assign wd     = ic0_axi_mst_wr_data[b0_bw-1:0];

  // Open-drain pins (TRI=1) only ever pull low; a high OUT releases the pad.
  assign drv_en  = dir_q & ~(tri_q & out_q);
  assign drv_val = out_q & ~tri_q;

  for (genvar i = 0; i < b0_bw; i++) begin : g_pad
    assign b0_data_io[i] = drv_en[i] ? drv_val[i] : 1'bz;
  end

  always_ff @(posedge clk or negedge c_sys_rst_n) begin
    if (!c_sys_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= b0_data_io;
      s2 <= s1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [7:0]       db_cnt [b0_bw];
  logic [b0_bw-1:0] f_q;

  // The filtered value only follows s2 once it has disagreed for DB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge c_sys_rst_n) begin
    if (!c_sys_rst_n) begin
      f_q <= '0;
      for (int i = 0; i < b0_bw; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < b0_bw; i++) begin
        if (s2[i] != f_q[i]) begin
          if (db_cnt[i] == 8'(DB_CYCLES - 1)) begin
            f_q[i]    <= s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign f = f_q;
`else
  localparam int unused_db_cycles = DB_CYCLES;
  assign f = s2;
`endif

  assign pend_hit = (f & ~prev & rise_en) | (~f & prev & fall_en);
  assign pend_clr = (ic0_c_axi_mst_wr_valid && wr_off == 32'h28) ? wd : '0;

  always_ff @(posedge clk or negedge c_sys_rst_n) begin
    if (!c_sys_rst_n) begin
      dir_q   <= '0;
      tri_q   <= '0;
      out_q   <= '0;
      rise_en <= '0;
      fall_en <= '0;
      mask    <= '0;
      pend    <= '0;
      prev    <= '0;
      irq     <= 1'b0;
    end else begin
      prev <= f;
      // A new edge on the same cycle as its W1C must not be lost, so the set term goes last.
      pend <= (pend & ~pend_clr) | pend_hit;
      irq  <= |(pend & mask);
      if (ic0_c_axi_mst_wr_valid) begin
        case (wr_off)
          32'h00:  dir_q   <= dir_q & ~wd;
          32'h04:  dir_q   <= dir_q | wd;
          32'h08:  tri_q   <= tri_q & ~wd;
          32'h0C:  tri_q   <= tri_q | wd;
          32'h10:  out_q   <= out_q & ~wd;
          32'h14:  out_q   <= out_q | wd;
          32'h18:  rise_en <= wd;
          32'h1C:  fall_en <= wd;
          32'h2C:  mask    <= wd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ic0_c_axi_slv_rd_ready_0 = 1'b0;
    ic0_axi_slv_rd_data_0    = '0;
    if (ic0_c_axi_mst_rd_valid) begin
      ic0_c_axi_slv_rd_ready_0 = 1'b1;
      case (rd_off)
        32'h18:  ic0_axi_slv_rd_data_0[b0_bw-1:0] = rise_en;
        32'h1C:  ic0_axi_slv_rd_data_0[b0_bw-1:0] = fall_en;
        32'h20:  ic0_axi_slv_rd_data_0[b0_bw-1:0] = f;
        32'h24:  ic0_axi_slv_rd_data_0[b0_bw-1:0] = out_q;
        32'h28:  ic0_axi_slv_rd_data_0[b0_bw-1:0] = pend;
        32'h2C:  ic0_axi_slv_rd_data_0[b0_bw-1:0] = mask;
        32'h30:  ic0_axi_slv_rd_data_0[b0_bw-1:0] = dir_q;
        32'h34:  ic0_axi_slv_rd_data_0[b0_bw-1:0] = tri_q;
        default: ic0_c_axi_slv_rd_ready_0 = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_irq_bank.sv
// Scoreboard bench for gpio_irq_bank (default build): random bus traffic and pad activity
// checked against a cycle-history reference model.
module tb_gpio_irq_bank;

  localparam logic [31:0] BASE = 32'h80030000;
  localparam int          W    = 8;

  typedef struct packed {
    logic        ready;
    logic [31:0] data;
    logic        irq;
    logic [W-1:0] pad;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  wire  [W-1:0] pads;
  logic [W-1:0] tb_en = '1;
  logic [W-1:0] tb_val = '0;
  logic         wr_valid = 1'b0, rd_valid = 1'b0;
  logic [31:0]  wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic         rd_ready, irq;
  logic [31:0]  rd_data;

  int checks = 0;
  int passes = 0;
  exp_t sb[$];

  // Reference model: architectural registers plus the history of pad samples taken at each edge.
  logic [W-1:0] m_dir, m_tri, m_out, m_rise, m_fall, m_pend, m_mask;
  logic         m_irq;
  logic [W-1:0] hist[$];
  logic [W-1:0] cur_tb = '0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_tbpad
    assign pads[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  gpio_irq_bank #(.BASE(BASE), .OFFSET(32'h0), .b0_bw(W), .DB_CYCLES(4)) dut (
    .clk                      (clk),
    .c_sys_rst_n              (rst_n),
    .b0_data_io               (pads),
    .ic0_c_axi_mst_wr_valid   (wr_valid),
    .ic0_axi_mst_wr_addr      (wr_addr),
    .ic0_axi_mst_wr_data      (wr_data),
    .ic0_c_axi_mst_rd_valid   (rd_valid),
    .ic0_axi_mst_rd_addr      (rd_addr),
    .ic0_c_axi_slv_rd_ready_0 (rd_ready),
    .ic0_axi_slv_rd_data_0    (rd_data),
    .irq                      (irq)
  );

  function automatic logic [W-1:0] histBack(int back);
    if (hist.size() > back) return hist[hist.size() - 1 - back];
    return '0;
  endfunction

  // A pin is driven when it is an output, unless it is open-drain with OUT=1.
  function automatic logic [W-1:0] driveEn();
    logic [W-1:0] en;
    en = '0;
    for (int i = 0; i < W; i++)
      en[i] = m_dir[i] && !(m_tri[i] && m_out[i]);
    return en;
  endfunction

  function automatic logic [W-1:0] modelPad();
    logic [W-1:0] p, en;
    en = driveEn();
    for (int i = 0; i < W; i++)
      p[i] = en[i] ? (m_tri[i] ? 1'b0 : m_out[i]) : tb_val[i];
    return p;
  endfunction

  task automatic modelReset();
    m_dir = '0; m_tri = '0; m_out = '0; m_rise = '0; m_fall = '0;
    m_pend = '0; m_mask = '0; m_irq = 1'b0;
    hist.delete();
  endtask

  function automatic void expRead(logic [31:0] addr, output logic ready, output logic [31:0] data);
    ready = 1'b1;
    data  = '0;
    case (addr - BASE)
      32'h18:  data[W-1:0] = m_rise;
      32'h1C:  data[W-1:0] = m_fall;
      32'h20:  data[W-1:0] = histBack(1);
      32'h24:  data[W-1:0] = m_out;
      32'h28:  data[W-1:0] = m_pend;
      32'h2C:  data[W-1:0] = m_mask;
      32'h30:  data[W-1:0] = m_dir;
      32'h34:  data[W-1:0] = m_tri;
      default: ready = 1'b0;
    endcase
  endfunction

  // One clock edge of the model: the input seen two edges ago is the filtered value, three ago is prev.
  task automatic modelEdge(logic wr, logic [31:0] waddr, logic [31:0] wdata);
    logic [W-1:0] sample, fv, pv, hits, clr, wd;
    logic [31:0]  off;
    sample = modelPad();
    fv     = histBack(1);
    pv     = histBack(2);
    wd     = wdata[W-1:0];
    off    = waddr - BASE;
    hits   = (fv & ~pv & m_rise) | (~fv & pv & m_fall);
    clr    = (wr && off == 32'h28) ? wd : '0;
    m_irq  = (m_pend & m_mask) != '0;
    m_pend = (m_pend & ~clr) | hits;
    if (wr) begin
      case (off)
        32'h00: m_dir  = m_dir & ~wd;
        32'h04: m_dir  = m_dir | wd;
        32'h08: m_tri  = m_tri & ~wd;
        32'h0C: m_tri  = m_tri | wd;
        32'h10: m_out  = m_out & ~wd;
        32'h14: m_out  = m_out | wd;
        32'h18: m_rise = wd;
        32'h1C: m_fall = wd;
        32'h2C: m_mask = wd;
        default: ;
      endcase
    end
    hist.push_back(sample);
    if (hist.size() > 6) void'(hist.pop_front());
  endtask

  task automatic applyStimulus(input logic rst_val, input logic wr, input logic [31:0] waddr,
                               input logic [31:0] wdata, input logic rd, input logic [31:0] raddr,
                               input logic [W-1:0] pad_in);
    exp_t e;
    @(negedge clk);
    rst_n = rst_val;
    if (!rst_val) modelReset();
    tb_val   = pad_in;
    tb_en    = ~driveEn();
    wr_valid = wr;
    wr_addr  = waddr;
    wr_data  = wdata;
    rd_valid = rd;
    rd_addr  = raddr;
    if (rd) begin
      expRead(raddr, e.ready, e.data);
      e.irq = m_irq;
      e.pad = modelPad();
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst_val) modelEdge(wr, waddr, wdata);
    tb_en = ~driveEn();
  endtask

  task automatic doWrite(input logic [31:0] off, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, BASE + off, data, 1'b0, 32'h0, cur_tb);
  endtask

  task automatic doRead(input logic [31:0] off);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, BASE + off, cur_tb);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, BASE + 32'h30, cur_tb);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, BASE + 32'h28, cur_tb);
  endtask

  task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard: read seen with no expectation queued");
      return;
    end
    e = sb.pop_front();
    compareField("rd_ready", 32'(rd_ready), 32'(e.ready));
    compareField("rd_data",  rd_data,       e.data);
    compareField("irq",      32'(irq),      32'(e.irq));
    compareField("pads",     32'(pads),     32'(e.pad));
  endtask

  // Monitor samples mid low-phase, well away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rd_valid) checkOutput();
    end
  end

  initial begin
    logic [31:0] off;
    int r;
    modelReset();
    $display("[TB] start");
    doReset();

    // Output drive and readback.
    doWrite(32'h04, 32'hFF);
    doWrite(32'h14, 32'h0F);
    doRead(32'h24);
    doWrite(32'h0C, 32'h01);
    doRead(32'h34);
    doWrite(32'h10, 32'h01);
    doRead(32'h24);

    // Rising edge on pin 1 raises PEND and irq, W1C drops them.
    doReset();
    doWrite(32'h18, 32'h02);
    doWrite(32'h2C, 32'h02);
    cur_tb = 8'h02;
    for (int i = 0; i < 5; i++) doRead(32'h28);
    applyStimulus(1'b1, 1'b1, BASE + 32'h28, 32'h02, 1'b1, BASE + 32'h28, cur_tb);
    for (int i = 0; i < 3; i++) doRead(32'h28);

    // Falling edge on pin 7 coinciding with its W1C.
    doWrite(32'h1C, 32'h80);
    doWrite(32'h2C, 32'h80);
    cur_tb = 8'h82;
    for (int i = 0; i < 4; i++) doRead(32'h20);
    cur_tb = 8'h02;
    doRead(32'h28);
    doRead(32'h28);
    doWrite(32'h28, 32'h80);
    doRead(32'h28);
    doRead(32'h28);
    doReset();

    // Unmapped read, write to read-only DATA_IN.
    cur_tb = 8'h5A;
    doRead(32'h40);
    doWrite(32'h20, 32'hFF);
    doRead(32'h20);
    doRead(32'h20);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic        wr, rd;
      logic [31:0] wa, ra;
      cur_tb = cur_tb ^ (W'($urandom) & W'($urandom) & W'($urandom));
      r  = $urandom_range(0, 99);
      wr = ($urandom_range(0, 99) < 35);
      rd = ($urandom_range(0, 99) < 60);
      off = 32'(4 * $urandom_range(0, 13));
      if (r < 4) off = 32'h40;
      else if (r < 7) off = off + 32'h1;
      wa = BASE + off;
      ra = BASE + 32'(4 * $urandom_range(0, 14));
      applyStimulus(($urandom_range(0, 199) != 0), wr, wa, $urandom, rd, ra, cur_tb);
    end

    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, cur_tb);
    @(negedge clk);
    #4;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
